// File: rtl/player_pkg.sv
// Shared definitions for the playback path: default widths, sample rate,
// silence code and the fetch FSM state encoding.
package player_pkg;

  localparam int PLAYER_ADDR_W    = 22;
  localparam int PLAYER_DATA_W    = 8;
  localparam int PLAYER_SAMPLE_HZ = 3000;

  // Mid-scale code for unsigned offset-binary audio: the output rests here
  localparam logic [PLAYER_DATA_W-1:0] PLAYER_SILENCIO = 8'h80;

  typedef enum logic [1:0] {
    OCIOSO,
    REQ,
    ESPERA,
    ENTREGA
  } estado_t;

endpackage

// File: rtl/divisor_tick.sv
// Sample-rate divider: one-cycle tick every DIV enabled cycles; the count is
// frozen while en is low so a resumed stream keeps its phase.
module divisor_tick #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/leitor_amostras.sv
// Paced audio sample reader: fetches one sample per period and strobes count
// to advance the address generator. Define LEITOR_PWM_EN to add pwm_out.
module leitor_amostras
  import player_pkg::*;
#(
  parameter int ADDR_W    = PLAYER_ADDR_W,
  parameter int DATA_W    = PLAYER_DATA_W,
  parameter int CLK_HZ    = 50000000,
  parameter int SAMPLE_HZ = PLAYER_SAMPLE_HZ,
  parameter int TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tocando,
  input  logic [ADDR_W-1:0] endereco,
  output logic              count,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] amostra,
  output logic              amostra_valida,
  output logic [7:0]        underrun
`ifdef LEITOR_PWM_EN
  ,
  output logic              pwm_out
`endif
);

  localparam int DIV  = CLK_HZ / SAMPLE_HZ;
  localparam int WC_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WC_W-1:0]   WC_LAST  = WC_W'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] SILENCIO = {1'b1, {(DATA_W-1){1'b0}}};

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  estado_t         state, state_next;
  logic            tick;
  logic            load_req, capture, timeout, drop;
  logic            captured;
  logic [WC_W-1:0] wcnt;

  divisor_tick #(.DIV(DIV)) u_div (
    .clk   (clk),
    .reset (reset),
    .en    (tocando),
    .tick  (tick)
  );

  always_comb begin
    state_next = state;
    load_req   = 1'b0;
    capture    = 1'b0;
    timeout    = 1'b0;
    case (state)
      OCIOSO: begin
        if (tick) begin
          state_next = REQ;
          load_req   = 1'b1;
        end
      end
      REQ:     state_next = ESPERA;
      ESPERA: begin
        // An ack on the last allowed cycle still wins over the timeout
        if (mem_ack) begin
          capture    = 1'b1;
          state_next = ENTREGA;
        end else if (wcnt == WC_LAST) begin
          timeout    = 1'b1;
          state_next = ENTREGA;
        end
      end
      ENTREGA: state_next = OCIOSO;
      default: state_next = OCIOSO;
    endcase
    drop = tick && (state != OCIOSO);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= OCIOSO;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      amostra  <= SILENCIO;
      captured <= 1'b0;
      wcnt     <= '0;
      underrun <= '0;
    end else begin
      state    <= state_next;
      captured <= capture;
      if (load_req) begin
        mem_req  <= 1'b1;
        mem_addr <= endereco;
        wcnt     <= '0;
      end else if (state == REQ || state == ESPERA) begin
        wcnt <= wcnt + 1'b1;
      end
      if (capture || timeout) mem_req <= 1'b0;
      if (capture) amostra <= mem_data;
      if (drop || timeout) underrun <= sat_inc(underrun);
    end
  end

  assign count          = (state == ENTREGA);
  assign amostra_valida = (state == ENTREGA) && captured;

`ifdef LEITOR_PWM_EN
  logic [DATA_W-1:0] pwm_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pwm_cnt <= '0;
      pwm_out <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      pwm_out <= (pwm_cnt < amostra);
    end
  end
`endif

endmodule

// File: tb/tb_leitor_amostras.sv
// Randomized bench for leitor_amostras: an edge-accurate behavioural model
// feeds a scoreboard of fetch outcomes consumed on every count pulse.
module tb_leitor_amostras;

  localparam int ADDR_W    = 22;
  localparam int DATA_W    = 8;
  localparam int CLK_HZ    = 30000;
  localparam int SAMPLE_HZ = 3000;
  localparam int TIMEOUT   = 16;
  localparam int DIV       = CLK_HZ / SAMPLE_HZ;

  logic              clk = 1'b0;
  logic              reset, tocando, mem_req, mem_ack, count, amostra_valida;
  logic [ADDR_W-1:0] endereco, mem_addr;
  logic [DATA_W-1:0] mem_data, amostra;
  logic [7:0]        underrun;
`ifdef LEITOR_PWM_EN
  logic              pwm_out;
`endif

  always #5 clk = ~clk;

  leitor_amostras #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CLK_HZ(CLK_HZ),
    .SAMPLE_HZ(SAMPLE_HZ), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .tocando(tocando), .endereco(endereco),
    .count(count), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_data(mem_data), .amostra(amostra),
    .amostra_valida(amostra_valida), .underrun(underrun)
`ifdef LEITOR_PWM_EN
    , .pwm_out(pwm_out)
`endif
  );

  typedef struct {
    logic       valid;
    logic [7:0] amostra;
  } resp_t;

  resp_t sb_q[$];
  int    checks = 0;
  int    errors = 0;
  int    edge_n = 0;

  // Expected DUT outputs after the most recently modelled clock edge
  logic              exp_count, exp_valid, exp_req;
  logic [ADDR_W-1:0] exp_addr;
  logic [7:0]        exp_amostra;
  int                exp_under;

  // Model of the fetch in flight (edge numbers)
  int  play_edges;
  bit  f_active, f_ack;
  int  f_start, f_end;

  // Stimulus knobs
  int         plan_d;
  logic [7:0] plan_data;
  int         knob_plan = 0;
  bit         knob_reset = 0, knob_fixed_addr = 0, knob_spur = 0, knob_pause = 0;
  int         knob_rst_mid = 0;
  int         pause_left = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, req, edge_n);
    end
  endtask

  // Behavioural prediction for one clock edge given the inputs seen at it
  task automatic model_step(input bit rst_v, input bit toc_v, input bit ack_v,
                            input logic [7:0] data_v, input logic [ADDR_W-1:0] addr_v);
    bit inc;
    exp_count = 1'b0;
    exp_valid = 1'b0;
    if (!rst_v) begin
      f_active    = 0;
      play_edges  = 0;
      exp_req     = 1'b0;
      exp_addr    = '0;
      exp_amostra = 8'h80;
      exp_under   = 0;
      sb_q.delete();
      return;
    end
    inc = 0;
    if (f_active && f_end >= 0 && edge_n > f_end + 1) f_active = 0;
    if (f_active && f_end < 0 && edge_n > f_start) begin
      if (edge_n >= f_start + 2 && ack_v) begin
        f_end = edge_n; f_ack = 1; exp_amostra = data_v;
      end else if (edge_n == f_start + TIMEOUT) begin
        f_end = edge_n; f_ack = 0; inc = 1;
      end
      if (f_end == edge_n) begin
        resp_t r;
        r.valid = f_ack; r.amostra = exp_amostra;
        sb_q.push_back(r);
      end
    end
    if (toc_v) begin
      play_edges++;
      if (play_edges % DIV == 0) begin
        if (f_active) inc = 1;
        else begin
          f_active = 1; f_start = edge_n; f_end = -1; exp_addr = addr_v;
        end
      end
    end
    if (inc) exp_under = (exp_under < 255) ? exp_under + 1 : 255;
    exp_req   = f_active && (f_end < 0);
    exp_count = f_active && (f_end == edge_n);
    exp_valid = exp_count && f_ack;
  endtask

  task automatic step_edge(input bit first);
    bit r, a;
    logic [7:0] dt;
    if (!first) @(negedge clk);
    edge_n++;
    r  = !knob_reset;
    a  = 1'b0;
    dt = 8'($urandom);
    if (knob_fixed_addr) endereco = 22'h000100;
    else if (count === 1'b1) endereco = endereco + 1'b1;
    else if ($urandom_range(0, 49) == 0) endereco = ADDR_W'($urandom);
    if (knob_pause && f_active && f_end < 0 && edge_n == f_start + 2 && pause_left == 0
        && $urandom_range(0, 1) == 1) pause_left = 60;
    tocando = (pause_left == 0);
    if (pause_left > 0) pause_left--;
    if (f_active && f_end < 0) begin
      if (plan_d > 0 && edge_n == f_start + 1 + plan_d) begin
        a = 1'b1; dt = plan_data;
      end else if (knob_spur && edge_n <= f_start + 1 && $urandom_range(0, 3) == 0) begin
        a = 1'b1;
      end
    end else if (knob_spur && $urandom_range(0, 7) == 0) begin
      a = 1'b1;
    end
    if (knob_rst_mid == 1 && f_active && f_end < 0 && edge_n == f_start + 1) begin
      r = 1'b0; knob_rst_mid = 2;
    end else if (knob_rst_mid == 2) begin
      a = 1'b1; dt = 8'h55; knob_rst_mid = 0;
    end
    reset = r; mem_ack = a; mem_data = dt;
    model_step(r, tocando, a, dt, endereco);
    if (f_active && f_start == edge_n) begin
      case (knob_plan)
        0:       begin plan_d = 1; plan_data = 8'h3C; end
        1:       begin plan_d = $urandom_range(1, 5); plan_data = 8'($urandom); end
        2:       begin plan_d = 0; plan_data = 8'h00; end
        3:       begin plan_d = 12; plan_data = 8'($urandom); end
        default: begin
          plan_d = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 14);
          plan_data = 8'($urandom);
        end
      endcase
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step_edge(1'b0);
  endtask

  // Monitor: per-edge output comparison plus scoreboard pop on count
  initial begin
`ifdef LEITOR_PWM_EN
    bit         pwm_hist[256];
    int         pwm_idx = 0, pwm_run = 0, pwm_sum;
    logic [7:0] pwm_last = 8'h00;
`endif
    resp_t r;
    forever begin
      @(posedge clk);
      #1;
      chk("count", count, exp_count);
      chk("amostra_valida", amostra_valida, exp_valid);
      chk("mem_req", mem_req, exp_req);
      chk("mem_addr", mem_addr, exp_addr);
      chk("amostra", amostra, exp_amostra);
      chk("underrun", underrun, exp_under);
      if (count === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_empty: count pulse with no pending fetch (edge %0d)", edge_n);
        end else begin
          r = sb_q.pop_front();
          chk("sb_valid", amostra_valida, r.valid);
          if (r.valid) chk("sb_amostra", amostra, r.amostra);
        end
      end
`ifdef LEITOR_PWM_EN
      if (reset !== 1'b1 || exp_amostra != pwm_last) pwm_run = 0;
      else pwm_run++;
      pwm_last = exp_amostra;
      pwm_hist[pwm_idx] = pwm_out;
      pwm_idx = (pwm_idx + 1) % 256;
      if (pwm_run >= 260 && pwm_idx == 0) begin
        pwm_sum = 0;
        for (int k = 0; k < 256; k++) pwm_sum += int'(pwm_hist[k]);
        chk("pwm_duty", pwm_sum, exp_amostra);
      end
`endif
    end
  end

  initial begin
    reset = 1'b0; tocando = 1'b0; endereco = '0; mem_ack = 1'b0; mem_data = '0;
    plan_d = 0; plan_data = 8'h00;
    knob_reset = 1;
    step_edge(1'b1);
    run(3);
    knob_reset = 0;

    knob_plan = 0; knob_fixed_addr = 1;
    run(80);
    knob_fixed_addr = 0; knob_plan = 1; knob_spur = 1;
    run(500);
    knob_plan = 2; knob_spur = 0;
    run(100);
    knob_plan = 3;
    run(120);
    knob_plan = 1; knob_pause = 1; knob_spur = 1;
    run(600);
    knob_pause = 0; knob_spur = 0; knob_plan = 0; knob_rst_mid = 1;
    run(100);
    knob_plan = 2;
    run(3000);
    chk("underrun_saturated", underrun, 8'd255);
    knob_plan = 4; knob_spur = 1;
    run(400);
    knob_reset = 1;
    run(3);
    knob_reset = 0;
    knob_plan = 0; knob_spur = 0;
    run(400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/leitor_amostras.md
Name: leitor_amostras

Overview:
- Consumer side of the playback address stream: paces sample fetches at the audio rate, reads audio memory at the current address, delivers one sample per period, and returns the `count` strobe that advances the address generator.
- Sits between the address ASM (supplies `endereco`, takes `count`) and the audio memory / output stage.
- Owns all playback timing; the address ASM only reacts to `count`.

Parameters:
- ADDR_W, 22, address width; matches `endereco`.
- DATA_W, 8, sample width.
- CLK_HZ, 50000000, system clock frequency.
- SAMPLE_HZ, 3000, sample rate; must match the address ASM's addresses per second.
- TIMEOUT, 64, max cycles to wait for `mem_ack` before abandoning a fetch (≥2).

Ports:
- clk, in, 1, system clock.
- reset, in, 1, synchronous, active-low.
- tocando, in, 1, 1 = play, 0 = pause.
- endereco, in, ADDR_W, current address from the address ASM.
- count, out, 1, one-cycle pulse; address ASM advances on it.
- mem_req, out, 1, read request to audio memory.
- mem_addr, out, ADDR_W, read address; held stable while `mem_req`=1.
- mem_ack, in, 1, memory accepted request; `mem_data` valid same cycle.
- mem_data, in, DATA_W, read data.
- amostra, out, DATA_W, current output sample; held between updates.
- amostra_valida, out, 1, one-cycle pulse when `amostra` updates.
- underrun, out, 8, saturating count of dropped ticks and timeouts.

Behaviour:
- Reset: all outputs at reset value when `reset`=0 at a clk edge.
  - 0: `count`, `mem_req`, `mem_addr`, `amostra_valida`, `underrun`.
  - Silence mid-code (1 followed by DATA_W-1 zeros, 0x80 for 8-bit): `amostra`.
  - State → OCIOSO; divider → 0.
  - Reset mid-fetch drops `mem_req` immediately; a late `mem_ack` is ignored.
- Divider: DIV = CLK_HZ/SAMPLE_HZ (integer).
  - Counter runs 0..DIV-1; `tick`=1 for one cycle when counter = DIV-1, then wraps to 0.
  - Counter runs only while `tocando`=1; holds its value when paused.
- FSM states:
  - OCIOSO: on `tick` → REQ.
  - REQ: one cycle. `mem_addr` ← `endereco` (registered), `mem_req` ← 1; → ESPERA.
  - ESPERA: `mem_req` held at 1, `mem_addr` stable, wait counter increments.
    - On `mem_ack`: capture `mem_data`, drop `mem_req`; → ENTREGA.
    - If wait counter reaches TIMEOUT-1 without ack: drop `mem_req`, `underrun`++, `amostra` unchanged; → ENTREGA.
  - ENTREGA: one cycle. `count`=1. `amostra_valida`=1 only if data was captured (`amostra` updates same edge); → OCIOSO.
- Latency: tick → `mem_req` high is 1 cycle. Ack → `amostra`/`amostra_valida`/`count` is 1 cycle.
- Address advance: exactly one `count` pulse per tick serviced, including timeouts, so playback never stalls on bad memory.
- Tick not in OCIOSO: tick dropped, `underrun`++. No queued fetch.
- Saturation: `underrun` sticks at 255. Double-increment in one cycle counts 1.
- Pause (`tocando`=0):
  - No new ticks.
  - A fetch in flight completes normally, including its `count`.
  - `amostra` holds its last value.
- `endereco` is sampled only in REQ; changes at other times (skip ±10 s) take effect on the next fetch.
- `mem_ack` outside ESPERA is ignored.

Optional Feature:
- Macro: `LEITOR_PWM_EN`.
- Defined:
  - Adds output `pwm_out` (1 bit): free-running DATA_W-bit counter.
  - `pwm_out` = (pwm counter < `amostra`).
  - Reset value 0; counter resets to 0.
- Undefined: no port, no counter. Sample consumed externally via `amostra`/`amostra_valida`.

Decomposition:
- Shared package `player_pkg`:
  - Constants: ADDR_W, DATA_W, SAMPLE_HZ, silence code.
  - State enum: OCIOSO, REQ, ESPERA, ENTREGA.
- SAMPLE_HZ shared with the address ASM so both agree on addresses per second.
- One sub-module, `divisor_tick`: parameter DIV, inputs `clk`/`reset`/`en`, output `tick`.
- FSM, timeout counter and optional PWM stay in the top.

Test Plan (bench: CLK_HZ=30000, SAMPLE_HZ=3000 → DIV=10):
- Play, memory acks 1 cycle after `mem_req` with `mem_data`=0x3C, `endereco`=0x000100 → `mem_addr`=0x000100, `amostra`=0x3C, one `amostra_valida` and one `count` every 10 cycles.
- Memory never acks, TIMEOUT=4 → `mem_req` drops after 4 cycles, `count` pulses, `amostra` stays 0x80, `underrun`=1, `amostra_valida` never pulses.
- Ack delayed 12 cycles → next tick dropped, `underrun`=1, `amostra` updates once, exactly one `count`.
- `tocando`→0 during ESPERA → fetch finishes with one `count`, then no `mem_req` for 50 cycles; resume → next tick after remaining divider count.
- `reset`=0 while `mem_req`=1, then `mem_ack` the next cycle → all outputs at reset values, no `count`, `amostra`=0x80.
- Force 300 timeouts → `underrun` saturates at 255. With `LEITOR_PWM_EN` and `amostra`=0x40 → `pwm_out` high 64 of every 256 cycles.
